// File: rtl/matmul_seq_ctrl.sv
// Loop-nest sequencer for the pipelined N x N matrix multiply: issues A/B operand reads,
// drives the MAC first/last sidebands, and emits C writes as results leave the datapath.
module matmul_seq_ctrl #(
   parameter int unsigned N          = 10,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PIPE_LAT   = 3,
   parameter int unsigned ADDR_W     = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              hold,
   output logic [ADDR_W-1:0] a_addr,
   output logic [ADDR_W-1:0] b_addr,
   output logic              op_valid,
   output logic              op_first,
   output logic              op_last,
   output logic              c_wr_en,
   output logic [ADDR_W-1:0] c_addr,
   output logic              busy,
   output logic              done,
   output logic [7:0]        LED
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DW = $clog2(PIPE_LAT + 1);
   localparam logic [CW-1:0]     LAST     = CW'(N - 1);
   localparam logic [ADDR_W-1:0] NA       = ADDR_W'(N);
   localparam logic [5:0]        ROWS_MAX = 6'(N);

   if (N < 2 || N > 63 || PIPE_LAT < 1 || DATA_WIDTH < 1 || ADDR_W < $clog2(N * N)) begin : g_bad_param
      $error("matmul_seq_ctrl: illegal parameter combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t            state_q;
   logic [CW-1:0]     i_q, j_q, k_q;
   logic [DW-1:0]     drain_q;
   logic [ADDR_W-1:0] a_addr_q, b_addr_q, iss_caddr_q;
   logic              op_valid_q, op_first_q, op_last_q, iss_clast_q;
   logic              busy_q, done_q, done_flag_q;
   logic [5:0]        rows_q;
   logic [PIPE_LAT-1:0] wr_sr_q, cl_sr_q;
   logic [ADDR_W-1:0]   ad_sr_q [PIPE_LAT];
   logic                issue_c;

   // An operand is issued on any edge where the loop nest is active and memory is ready.
   assign issue_c = !hold && ((state_q == S_IDLE && start) || state_q == S_ISSUE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         j_q         <= '0;
         k_q         <= '0;
         drain_q     <= '0;
         a_addr_q    <= '0;
         b_addr_q    <= '0;
         iss_caddr_q <= '0;
         op_valid_q  <= 1'b0;
         op_first_q  <= 1'b0;
         op_last_q   <= 1'b0;
         iss_clast_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         done_flag_q <= 1'b0;
         rows_q      <= '0;
         wr_sr_q     <= '0;
         cl_sr_q     <= '0;
         for (int s = 0; s < int'(PIPE_LAT); s++) ad_sr_q[s] <= '0;
      end else begin
         // Latency line: stall bubbles enter as zero write strobes.
         for (int s = int'(PIPE_LAT) - 1; s > 0; s--) begin
            wr_sr_q[s] <= wr_sr_q[s-1];
            cl_sr_q[s] <= cl_sr_q[s-1];
            ad_sr_q[s] <= ad_sr_q[s-1];
         end
         wr_sr_q[0] <= op_valid_q & op_last_q;
         cl_sr_q[0] <= iss_clast_q;
         ad_sr_q[0] <= iss_caddr_q;

         if (wr_sr_q[PIPE_LAT-1] && cl_sr_q[PIPE_LAT-1] && rows_q != ROWS_MAX)
            rows_q <= rows_q + 6'd1;

         op_valid_q <= 1'b0;
         op_first_q <= 1'b0;
         op_last_q  <= 1'b0;

         if (issue_c) begin
            a_addr_q    <= ADDR_W'(i_q) * NA + ADDR_W'(k_q);
            b_addr_q    <= ADDR_W'(k_q) * NA + ADDR_W'(j_q);
            iss_caddr_q <= ADDR_W'(i_q) * NA + ADDR_W'(j_q);
            iss_clast_q <= (j_q == LAST);
            op_valid_q  <= 1'b1;
            op_first_q  <= (k_q == '0);
            op_last_q   <= (k_q == LAST);
            if (k_q == LAST) begin
               k_q <= '0;
               if (j_q == LAST) begin
                  j_q <= '0;
                  if (i_q == LAST) begin
                     i_q     <= '0;
                     state_q <= S_DRAIN;
                     drain_q <= '0;
                  end else begin
                     i_q <= i_q + CW'(1);
                  end
               end else begin
                  j_q <= j_q + CW'(1);
               end
            end else begin
               k_q <= k_q + CW'(1);
            end
         end

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q     <= S_ISSUE;
                  busy_q      <= 1'b1;
                  done_flag_q <= 1'b0;
                  rows_q      <= '0;
               end
            end
            S_ISSUE: ;
            S_DRAIN: begin
               if (drain_q == DW'(PIPE_LAT)) begin
                  state_q     <= S_DONE;
                  done_q      <= 1'b1;
                  done_flag_q <= 1'b1;
               end else begin
                  drain_q <= drain_q + DW'(1);
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign a_addr   = a_addr_q;
   assign b_addr   = b_addr_q;
   assign op_valid = op_valid_q;
   assign op_first = op_first_q;
   assign op_last  = op_last_q;
   assign c_wr_en  = wr_sr_q[PIPE_LAT-1];
   assign c_addr   = ad_sr_q[PIPE_LAT-1];
   assign busy     = busy_q;
   assign done     = done_q;
   assign LED      = {busy_q, done_flag_q, rows_q};

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl (N=10, PIPE_LAT=3): timing, hold, reset and restart cases.
module tb_matmul_seq_ctrl;

   logic       clk, rst, start, hold;
   logic [6:0] a_addr, b_addr, c_addr;
   logic       op_valid, op_first, op_last, c_wr_en, busy, done;
   logic [7:0] LED;

   int checks = 0;
   int errors = 0;

   matmul_seq_ctrl #(.N(10), .DATA_WIDTH(8), .PIPE_LAT(3), .ADDR_W(7)) dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold),
      .a_addr(a_addr), .b_addr(b_addr), .op_valid(op_valid), .op_first(op_first),
      .op_last(op_last), .c_wr_en(c_wr_en), .c_addr(c_addr), .busy(busy),
      .done(done), .LED(LED)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ops"}, {29'd0, op_valid, op_first, op_last}, 32'd0);
      chk({tag, "_addr"}, {11'd0, a_addr, b_addr, c_addr}, 32'd0);
      chk({tag, "_flags"}, {29'd0, c_wr_en, busy, done}, 32'd0);
      chk({tag, "_led"}, 32'(LED), 32'h00);
   endtask

   // One full job from a start in cycle 0; cycle n is the interval after the n-th edge.
   task automatic run_job(input string tag, input int hold_at, input int hold_len,
                          input bit poke, input bit keep);
      int nops, nwr, ncl, ndone, done_cyc, bad_op, bad_wr, last_wr_cyc, last_wr_addr;
      int ei, ej, ek, exp_done;
      int last_cyc [100];
      nops = 0; nwr = 0; ncl = 0; ndone = 0; done_cyc = -1; bad_op = 0; bad_wr = 0;
      last_wr_cyc = -1; last_wr_addr = -1;
      exp_done = 1004 + hold_len;
      start = 1'b1;
      step();
      if (!keep) start = 1'b0;
      for (int n = 1; n <= exp_done + 1; n++) begin
         if (op_valid) begin
            ei = nops / 100; ej = (nops / 10) % 10; ek = nops % 10;
            if (int'(a_addr) != ei * 10 + ek || int'(b_addr) != ek * 10 + ej ||
                op_first != (ek == 0) || op_last != (ek == 9)) bad_op++;
            if (op_last) begin
               if (ncl < 100) last_cyc[ncl] = n;
               ncl++;
            end
            nops++;
         end else if (op_first || op_last) begin
            bad_op++;
         end
         if (n == 1) begin
            chk({tag, "_first_issue"}, {29'd0, op_valid, op_first, busy}, 32'd7);
            chk({tag, "_first_addr"}, {18'd0, a_addr, b_addr}, 32'd0);
         end
         if (n == 10) chk({tag, "_first_last"}, {17'd0, op_last, a_addr, b_addr},
                          {17'd0, 1'b1, 7'd9, 7'd90});
         if (hold_len > 0 && (n == hold_at + 1 || n == hold_at + hold_len))
            chk({tag, "_hold_frozen"}, {17'd0, op_valid, a_addr, b_addr},
                {17'd0, 1'b0, 7'd24, 7'd43});
         if (c_wr_en) begin
            if (nwr == 0) chk({tag, "_first_wr"}, 32'(n * 128 + int'(c_addr)), 32'(13 * 128));
            if (nwr >= ncl || nwr >= 100) bad_wr++;
            else if (n != last_cyc[nwr] + 3 || int'(c_addr) != nwr) bad_wr++;
            last_wr_cyc = n; last_wr_addr = int'(c_addr);
            nwr++;
         end
         if (done) begin
            ndone++;
            done_cyc = n;
            chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
         end
         if (n == exp_done + 1) begin
            chk({tag, "_led_after"}, 32'(LED), 32'h4A);
            chk({tag, "_busy_after"}, {30'd0, busy, done}, 32'd0);
         end
         hold = (n >= hold_at && n < hold_at + hold_len);
         start = keep ? 1'b1 : (poke && (n == 50 || n == 1001));
         step();
      end
      chk({tag, "_n_ops"}, 32'(nops), 32'd1000);
      chk({tag, "_n_wr"}, 32'(nwr), 32'd100);
      chk({tag, "_op_seq_bad"}, 32'(bad_op), 32'd0);
      chk({tag, "_wr_seq_bad"}, 32'(bad_wr), 32'd0);
      chk({tag, "_last_wr_cyc"}, 32'(last_wr_cyc), 32'(1003 + hold_len));
      chk({tag, "_last_wr_addr"}, 32'(last_wr_addr), 32'd99);
      chk({tag, "_n_done"}, 32'(ndone), 32'd1);
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
   endtask

   initial begin
      int stray;
      rst = 1'b1; start = 1'b0; hold = 1'b0;
      step();
      step();
      chk_idle_outputs("reset");
      rst = 1'b0;
      step();
      chk_idle_outputs("idle");

      run_job("nominal", -100, 0, 1'b0, 1'b0);
      step();
      run_job("hold", 235, 5, 1'b0, 1'b0);
      step();
      run_job("poke", -100, 0, 1'b1, 1'b0);
      step();

      // Reset once 500 operands have been issued.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n < 500; n++) step();
      chk("midrst_pre", 32'(op_valid), 32'd1);
      rst = 1'b1;
      step();
      chk_idle_outputs("midrst");
      rst = 1'b0;
      stray = 0;
      for (int n = 0; n < 20; n++) begin
         step();
         if (c_wr_en || op_valid || busy) stray++;
      end
      chk("midrst_quiet", 32'(stray), 32'd0);
      run_job("replay", -100, 0, 1'b0, 1'b0);
      step();

      // Start held high through DONE: next job begins right after IDLE re-entry.
      run_job("b2b", -100, 0, 1'b0, 1'b1);
      chk("b2b_restart", {17'd0, op_valid, a_addr, b_addr}, {17'd0, 1'b1, 7'd0, 7'd0});
      chk("b2b_first", 32'(op_first), 32'd1);
      chk("b2b_led", 32'(LED), 32'h80);
      start = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle_outputs("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
